// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter: op encoding,
// stage-placement helper and a behavioural reference shift.
package shifter_pkg;

  typedef enum logic [2:0] {
    SHL = 3'd0,
    SHR = 3'd1,
    SAR = 3'd2,
    ROL = 3'd3,
    ROR = 3'd4
  } shift_op_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= 3'(ROR);
  endfunction

  // In unpipelined mode only the final mux level carries a register.
  function automatic int is_registered(input int pipeline, input int level, input int levels);
    return (pipeline != 0 || level == levels - 1) ? 1 : 0;
  endfunction

  // Bit-by-bit reference shift for widths up to 64.
  function automatic logic [63:0] ref_shift(input logic [63:0] data, input int unsigned shamt,
                                            input logic [2:0] op, input int unsigned width);
    logic [63:0] r;
    logic        sgn;
    int unsigned rs;
    int unsigned src;
    r   = '0;
    sgn = data[6'(width - 1)];
    rs  = shamt % width;
    for (int unsigned i = 0; i < width; i++) begin
      src = i + shamt;
      case (op)
        SHL:     r[6'(i)] = (i >= shamt) ? data[6'(i - shamt)] : 1'b0;
        SHR:     r[6'(i)] = (src < width) ? data[6'(src)] : 1'b0;
        SAR:     r[6'(i)] = (src < width) ? data[6'(src)] : sgn;
        ROL:     r[6'(i)] = data[6'((i + width - rs) % width)];
        ROR:     r[6'(i)] = data[6'((i + rs) % width)];
        default: r[6'(i)] = data[6'(i)];
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/shifter_level.sv
// One barrel-shifter mux level: shifts by 2**K when shamt bit K is set,
// optionally followed by a valid/ready stage register.
module shifter_level
  import shifter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 4,
  parameter int LEVELS     = 5,
  parameter int K          = 0,
  parameter int REGISTERED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [LEVELS-1:0] i_shamt,
  input  logic [2:0]        i_op,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_err,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WIDTH-1:0]  o_data,
  output logic [LEVELS-1:0] o_shamt,
  output logic [2:0]        o_op,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_err
);

  localparam int DIST = 1 << K;

  logic [WIDTH-1:0] w_shifted;

  always_comb begin
    w_shifted = i_data;
    if (i_shamt[K]) begin
      case (i_op)
        SHL:     w_shifted = i_data << DIST;
        SHR:     w_shifted = i_data >> DIST;
        SAR:     w_shifted = $signed(i_data) >>> DIST;
        ROL:     w_shifted = (i_data << DIST) | (i_data >> (WIDTH - DIST));
        ROR:     w_shifted = (i_data >> DIST) | (i_data << (WIDTH - DIST));
        default: w_shifted = i_data;
      endcase
    end
  end

  if (REGISTERED != 0) begin : g_reg
    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [LEVELS-1:0] r_shamt;
    logic [2:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic              r_err;

    // A full stage only reloads once downstream takes its current word.
    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_shamt <= '0;
        r_op    <= '0;
        r_tag   <= '0;
        r_err   <= 1'b0;
      end else if (o_ready) begin
        r_valid <= i_valid;
        if (i_valid) begin
          r_data  <= w_shifted;
          r_shamt <= i_shamt;
          r_op    <= i_op;
          r_tag   <= i_tag;
          r_err   <= i_err;
        end
      end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_shamt = r_shamt;
    assign o_op    = r_op;
    assign o_tag   = r_tag;
    assign o_err   = r_err;
  end else begin : g_comb
    logic w_unused_clk;
    assign w_unused_clk = clk ^ rst_n;
    assign o_ready = i_ready;
    assign o_valid = i_valid;
    assign o_data  = w_shifted;
    assign o_shamt = i_shamt;
    assign o_op    = i_op;
    assign o_tag   = i_tag;
    assign o_err   = i_err;
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Log2 barrel shifter with valid/ready flow control; out-of-range amounts and
// illegal ops are normalised in a combinational pre-stage.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int TAG_W    = 4,
  parameter int PIPELINE = 1,
  parameter int LEVELS   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [LEVELS:0]   in_shamt,
  input  logic [2:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  logic              w_big;
  logic [WIDTH-1:0]  w_pre_data;
  logic [LEVELS-1:0] w_pre_shamt;
  logic              w_pre_err;
  logic              w_unused_tail;

  assign w_big     = in_shamt[LEVELS];
  assign w_pre_err = !op_legal(in_op);

  // SAR saturates to WIDTH-1 so the levels fill every bit with the sign.
  always_comb begin
    w_pre_data  = in_data;
    w_pre_shamt = in_shamt[LEVELS-1:0];
    case (in_op)
      SHL, SHR: if (w_big) begin
        w_pre_data  = '0;
        w_pre_shamt = '0;
      end
      SAR:      if (w_big) w_pre_shamt = '1;
      ROL, ROR: w_pre_shamt = in_shamt[LEVELS-1:0];
      default:  w_pre_shamt = '0;
    endcase
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    logic              w_vin, w_vout, w_rdy_up, w_rdy_dn;
    logic [WIDTH-1:0]  w_din, w_dout;
    logic [LEVELS-1:0] w_sin, w_sout;
    logic [2:0]        w_oin, w_oout;
    logic [TAG_W-1:0]  w_tin, w_tout;
    logic              w_ein, w_eout;

    if (k == 0) begin : g_head
      assign w_vin = in_valid;
      assign w_din = w_pre_data;
      assign w_sin = w_pre_shamt;
      assign w_oin = in_op;
      assign w_tin = in_tag;
      assign w_ein = w_pre_err;
    end else begin : g_link
      assign w_vin = g_lvl[k-1].w_vout;
      assign w_din = g_lvl[k-1].w_dout;
      assign w_sin = g_lvl[k-1].w_sout;
      assign w_oin = g_lvl[k-1].w_oout;
      assign w_tin = g_lvl[k-1].w_tout;
      assign w_ein = g_lvl[k-1].w_eout;
    end

    if (k == LEVELS - 1) begin : g_tail
      assign w_rdy_dn = out_ready;
    end else begin : g_next
      assign w_rdy_dn = g_lvl[k+1].w_rdy_up;
    end

    shifter_level #(
      .WIDTH     (WIDTH),
      .TAG_W     (TAG_W),
      .LEVELS    (LEVELS),
      .K         (k),
      .REGISTERED(is_registered(PIPELINE, k, LEVELS))
    ) u_level (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_valid(w_vin),
      .o_ready(w_rdy_up),
      .i_data (w_din),
      .i_shamt(w_sin),
      .i_op   (w_oin),
      .i_tag  (w_tin),
      .i_err  (w_ein),
      .o_valid(w_vout),
      .i_ready(w_rdy_dn),
      .o_data (w_dout),
      .o_shamt(w_sout),
      .o_op   (w_oout),
      .o_tag  (w_tout),
      .o_err  (w_eout)
    );
  end

  assign in_ready      = g_lvl[0].w_rdy_up;
  assign out_valid     = g_lvl[LEVELS-1].w_vout;
  assign out_data      = g_lvl[LEVELS-1].w_dout;
  assign out_tag       = g_lvl[LEVELS-1].w_tout;
  assign out_err       = g_lvl[LEVELS-1].w_eout;
  assign w_unused_tail = ^{g_lvl[LEVELS-1].w_sout, g_lvl[LEVELS-1].w_oout};

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready |=> out_valid && $stable({out_data, out_tag, out_err}));

  a_shamt_known: assert property (@(posedge clk) disable iff (!rst_n)
    in_valid |-> !$isunknown(in_shamt));

endmodule
